normalizer_seq: RTL and testbench

Multi-cycle left normalizer: accepts a word, shifts it left one bit per cycle until the MSB is set, and returns the normalized word with the shift count taken. It is the inverse partner of the team's combinational barrel shifter: a logical right shift of `dOUT` by `ShAmount` restores `dIN`. It sits in front of arithmetic datapaths that need normalized operands and their exponent adjustment, such as leading-zero count and float packing.

---
 rtl/shifter_pkg.sv | 5 +
 rtl/normalizer_step.sv | 27 ++
 rtl/normalizer_seq.sv | 66 ++++++
 tb/tb_normalizer_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared types and constants for the normalizer
package shifter_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t;
  localparam int NIBBLE = 4;
endpackage

// File: rtl/normalizer_step.sv
// normalizer_step: one combinational normalization step (nibble skip under NORMALIZER_NIBBLE_SKIP_EN)
module normalizer_step
  import shifter_pkg::*;
#(
  parameter int BitWidth = 8,
  localparam int ShiftWidth = $clog2(BitWidth)
) (
  input  logic [BitWidth-1:0]   work,
  input  logic [ShiftWidth-1:0] count,
  output logic [BitWidth-1:0]   work_next,
  output logic [ShiftWidth-1:0] count_next,
  output logic                  done,
  output logic                  is_zero
);
  logic skip;
  always_comb begin
    is_zero = work == '0;
    done = is_zero || work[BitWidth-1];
`ifdef NORMALIZER_NIBBLE_SKIP_EN
    skip = !is_zero && work[BitWidth-1 -: NIBBLE] == '0;
`else
    skip = 1'b0;
`endif
    work_next = skip ? work << NIBBLE : work << 1;
    count_next = count + (skip ? ShiftWidth'(NIBBLE) : ShiftWidth'(1));
  end
endmodule

// File: rtl/normalizer_seq.sv
// normalizer_seq: multi-cycle left normalizer with valid/ready handshake
// Optional NORMALIZER_NIBBLE_SKIP_EN enables 4-bit steps inside normalizer_step.
module normalizer_seq
  import shifter_pkg::*;
#(
  parameter int BitWidth = 8,
  localparam int ShiftWidth = $clog2(BitWidth)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [BitWidth-1:0]   dIN,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [BitWidth-1:0]   dOUT,
  output logic [ShiftWidth-1:0] ShAmount,
  output logic                  Zero
);
  norm_state_t state, next_state;
  logic [BitWidth-1:0] work, work_next;
  logic [ShiftWidth-1:0] count, count_next;
  logic done, is_zero;
  normalizer_step #(.BitWidth(BitWidth)) step (
    .work(work),
    .count(count),
    .work_next(work_next),
    .count_next(count_next),
    .done(done),
    .is_zero(is_zero)
  );
  assign InReady = state == IDLE && !Reset;
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    next_state = state == IDLE  ? (InValid ? SHIFT : IDLE) :
                 state == SHIFT ? (done ? DONE : SHIFT) :
                                  (OutReady ? IDLE : DONE);
  end
  // Result registers load only on the SHIFT->DONE edge, so they hold through DONE.
  always_ff @(posedge Clk)
    if (Reset) begin
      work <= '0;
      count <= '0;
      dOUT <= '0;
      ShAmount <= '0;
      Zero <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      if (state == IDLE && InValid) begin
        work <= dIN;
        count <= '0;
      end else if (state == SHIFT && !done) begin
        work <= work_next;
        count <= count_next;
      end
      if (state == SHIFT && done) begin
        dOUT <= work;
        ShAmount <= is_zero ? '0 : count;
        Zero <= is_zero;
      end
      OutValid <= next_state == DONE;
    end
endmodule

// File: tb/tb_normalizer_seq.sv
// tb_normalizer_seq: directed table, corner sequences and random stream against a reference model
module tb_normalizer_seq;
  logic       Clk, Reset, InValid, InReady, OutValid, OutReady, Zero;
  logic [7:0] dIN, dOUT;
  logic [2:0] ShAmount;
  int tests = 0, fails = 0;

  normalizer_seq #(.BitWidth(8)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .InValid(InValid),
    .InReady(InReady),
    .dIN(dIN),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .dOUT(dOUT),
    .ShAmount(ShAmount),
    .Zero(Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] sh;
    logic       zero;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) if (d[i]) return 7 - i;
    return 8;
  endfunction

  function automatic int model_lat(input logic [7:0] d);
    int k;
    k = lead_zeros(d);
    if (d == 8'h00) return 1;
`ifdef NORMALIZER_NIBBLE_SKIP_EN
    return k / 4 + k % 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // One complete job: accept, measure latency, stall with a stray InValid pulse, then handshake.
  task automatic run_job(input string name, input logic [7:0] d, input logic [7:0] e_dout,
                         input logic [2:0] e_sh, input logic e_z, input int e_lat, input int stall);
    int n, lat;
    n = 0;
    while (!InReady && n < 50) begin tick(); n++; end
    check({name, "_in_ready"}, InReady, 1);
    InValid = 1'b1;
    dIN = d;
    tick();
    InValid = 1'b0;
    dIN = 8'($urandom);
    lat = 0;
    do begin tick(); lat++; end while (!OutValid && lat < 40);
    check({name, "_latency"}, lat, e_lat);
    check({name, "_dout"}, dOUT, e_dout);
    check({name, "_sh"}, ShAmount, e_sh);
    check({name, "_zero"}, Zero, e_z);
    if (!Zero) begin
      check({name, "_restore"}, dOUT >> ShAmount, d);
      check({name, "_msb"}, dOUT[7], 1);
    end
    for (int i = 0; i < stall; i++) begin
      InValid = i == 1;
      dIN = 8'hFF;
      check({name, "_hold_ready"}, InReady, 0);
      tick();
      check({name, "_hold_valid"}, OutValid, 1);
      check({name, "_hold_dout"}, dOUT, e_dout);
      check({name, "_hold_sh"}, ShAmount, e_sh);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({name, "_valid_fall"}, OutValid, 0);
    check({name, "_ready_rise"}, InReady, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    int k;
`ifdef NORMALIZER_NIBBLE_SKIP_EN
    vecs[0] = '{8'h80, 8'h80, 3'd0, 1'b0, 1};
    vecs[1] = '{8'h01, 8'h80, 3'd7, 1'b0, 5};
    vecs[2] = '{8'h00, 8'h00, 3'd0, 1'b1, 1};
    vecs[3] = '{8'h13, 8'h98, 3'd3, 1'b0, 4};
    vecs[4] = '{8'h0F, 8'hF0, 3'd4, 1'b0, 2};
    vecs[5] = '{8'h40, 8'h80, 3'd1, 1'b0, 2};
`else
    vecs[0] = '{8'h80, 8'h80, 3'd0, 1'b0, 1};
    vecs[1] = '{8'h01, 8'h80, 3'd7, 1'b0, 8};
    vecs[2] = '{8'h00, 8'h00, 3'd0, 1'b1, 1};
    vecs[3] = '{8'h13, 8'h98, 3'd3, 1'b0, 4};
    vecs[4] = '{8'h0F, 8'hF0, 3'd4, 1'b0, 5};
    vecs[5] = '{8'h40, 8'h80, 3'd1, 1'b0, 2};
`endif
    Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    dIN = 8'h00;
    tick();
    tick();
    check("rst_in_ready", InReady, 0);
    check("rst_valid", OutValid, 0);
    check("rst_dout", dOUT, 0);
    check("rst_sh", ShAmount, 0);
    check("rst_zero", Zero, 0);
    Reset = 1'b0;
    #1;
    check("rst_release_ready", InReady, 1);

    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout, vecs[i].sh, vecs[i].zero, vecs[i].lat, 0);

    run_job("backpressure", 8'h13, 8'h98, 3'd3, 1'b0, 4, 5);
    tick();
    check("bp_no_phantom", OutValid, 0);
    check("bp_idle", InReady, 1);

    InValid = 1'b1;
    dIN = 8'h01;
    tick();
    InValid = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("midrst_ready_low", InReady, 0);
    tick();
    check("midrst_valid", OutValid, 0);
    check("midrst_dout", dOUT, 0);
    check("midrst_sh", ShAmount, 0);
    check("midrst_zero", Zero, 0);
    Reset = 1'b0;
    #1;
    check("midrst_ready", InReady, 1);
    tick();
    check("midrst_no_result", OutValid, 0);
    run_job("after_rst", 8'h40, 8'h80, 3'd1, 1'b0, 2, 0);

    for (int j = 0; j < 1000; j++) begin
      d = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      k = lead_zeros(d);
      run_job("rand", d, d == 8'h00 ? 8'h00 : 8'(d << k), d == 8'h00 ? 3'd0 : 3'(k),
              d == 8'h00, model_lat(d), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
